// File: rtl/tea_stream_pkg.sv
// Shared constants for the TEA stream feeder: register map, register bit
// positions and the handshake state encoding.
package tea_stream_pkg;

  localparam logic [3:0] ADDR_TX   = 4'h0;
  localparam logic [3:0] ADDR_RX   = 4'h4;
  localparam logic [3:0] ADDR_STAT = 4'h8;
  localparam logic [3:0] ADDR_CTRL = 4'hC;

  localparam int ST_TX_EMPTY   = 0;
  localparam int ST_TX_FULL    = 1;
  localparam int ST_RX_EMPTY   = 2;
  localparam int ST_RX_FULL    = 3;
  localparam int ST_BUSY       = 4;
  localparam int ST_TX_CNT_LSB = 8;
  localparam int ST_RX_CNT_LSB = 16;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_FLUSH  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } fsm_t;

endpackage

// File: rtl/tea_stream_feeder_if.sv
// APB slave bus of the TEA stream feeder, grouped so the bench and any
// future bus wrapper connect through one port.
interface tea_stream_feeder_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/tea_sfifo.sv
// Synchronous 32-bit FIFO with single-cycle flush. Push while full and pop
// while empty are ignored; flush overrides both in the same cycle.
module tea_sfifo #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          pclk,
  input  logic          prstb,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [31:0]   din,
  output logic [31:0]   dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally at DEPTH; simultaneous push and pop keep count.
  always_ff @(posedge pclk or negedge prstb) begin
    if (!prstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage array needs no reset; only entries below count are ever read out.
  always_ff @(posedge pclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/tea_stream_feeder.sv
// APB-programmable front end that streams words from a TX FIFO through a
// TEA cipher core over a four-phase req/ack handshake into an RX FIFO.
module tea_stream_feeder
  import tea_stream_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int AW       = $clog2(DEPTH),
  parameter int ACK_SYNC = 2
) (
  input  logic                pclk,
  input  logic                prstb,
  tea_stream_feeder_if.slave  apb,
  output logic                req,
  output logic [31:0]         wdata,
  input  logic                ack,
  input  logic [31:0]         rdata,
  output logic                irq
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_REQ  = REQ;
  localparam logic [1:0] S_REL  = REL;

  logic [1:0]  state;
  logic        enable;
  logic        irq_en;
  logic        discard;
  logic        access;
  logic        wr_tx;
  logic        rd_rx;
  logic        wr_ctrl;
  logic        flush;
  logic        launch;
  logic        rx_push;
  logic        ack_s;
  logic [31:0] tx_dout;
  logic [31:0] rx_dout;
  logic [AW:0] tx_count;
  logic [AW:0] rx_count;
  logic        tx_full;
  logic        tx_empty;
  logic        rx_full;
  logic        rx_empty;
  logic [31:0] status;
  logic [31:0] prdata_c;
  logic        pslverr_c;

  assign access  = apb.psel & apb.penable;
  assign wr_tx   = access & apb.pwrite & (apb.paddr == ADDR_TX);
  assign rd_rx   = access & ~apb.pwrite & (apb.paddr == ADDR_RX);
  assign wr_ctrl = access & apb.pwrite & (apb.paddr == ADDR_CTRL);
  assign flush   = wr_ctrl & apb.pwdata[CTRL_FLUSH];

  // A word is launched only when its result is guaranteed a slot in RX.
  assign launch  = (state == S_IDLE) & enable & ~tx_empty & ~rx_full & ~flush;
  assign rx_push = (state == S_REQ) & ack_s & ~discard;

  tea_sfifo #(.DEPTH(DEPTH), .AW(AW)) u_tx_fifo (
    .pclk  (pclk),
    .prstb (prstb),
    .push  (wr_tx),
    .pop   (launch),
    .flush (flush),
    .din   (apb.pwdata),
    .dout  (tx_dout),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  tea_sfifo #(.DEPTH(DEPTH), .AW(AW)) u_rx_fifo (
    .pclk  (pclk),
    .prstb (prstb),
    .push  (rx_push),
    .pop   (rd_rx),
    .flush (flush),
    .din   (rdata),
    .dout  (rx_dout),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  logic [ACK_SYNC:0] ack_chain;
  assign ack_chain[0] = ack;
  assign ack_s        = ack_chain[ACK_SYNC];

  generate
    if (ACK_SYNC > 0) begin : g_ack_sync
      // Shift the asynchronous ack through the synchroniser chain.
      always_ff @(posedge pclk or negedge prstb) begin
        if (!prstb) ack_chain[ACK_SYNC:1] <= '0;
        else        ack_chain[ACK_SYNC:1] <= ack_chain[ACK_SYNC-1:0];
      end
    end
  endgenerate

  // Software control bits; flush is a pulse and is never stored.
  always_ff @(posedge pclk or negedge prstb) begin
    if (!prstb) begin
      enable <= 1'b0;
      irq_en <= 1'b0;
    end else if (wr_ctrl) begin
      enable <= apb.pwdata[CTRL_EN];
      irq_en <= apb.pwdata[CTRL_IRQ_EN];
    end
  end

  // Four-phase handshake; a flush during REQ lets it finish but drops the result.
  always_ff @(posedge pclk or negedge prstb) begin
    if (!prstb) begin
      state   <= S_IDLE;
      req     <= 1'b0;
      wdata   <= '0;
      discard <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (launch) begin
            state <= S_REQ;
            req   <= 1'b1;
            wdata <= tx_dout;
          end
        end
        S_REQ: begin
          if (ack_s) begin
            state   <= S_REL;
            req     <= 1'b0;
            discard <= 1'b0;
          end else if (flush) begin
            discard <= 1'b1;
          end
        end
        S_REL: begin
          if (!ack_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Level interrupt, registered from the current RX occupancy.
  always_ff @(posedge pclk or negedge prstb) begin
    if (!prstb) irq <= 1'b0;
    else        irq <= irq_en & ~rx_empty;
  end

  // Assemble the STATUS word from FIFO flags and counts.
  always_comb begin
    status = '0;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_TX_FULL]  = tx_full;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_BUSY]     = (state != S_IDLE);
    status[ST_TX_CNT_LSB +: AW+1] = tx_count;
    status[ST_RX_CNT_LSB +: AW+1] = rx_count;
  end

  // Decode the APB access phase into read data and error response.
  always_comb begin
    prdata_c  = '0;
    pslverr_c = 1'b0;
    if (access) begin
      case (apb.paddr)
        ADDR_TX: begin
          if (apb.pwrite) pslverr_c = tx_full;
          else            pslverr_c = 1'b1;
        end
        ADDR_RX: begin
          if (apb.pwrite || rx_empty) pslverr_c = 1'b1;
          else                        prdata_c  = rx_dout;
        end
        ADDR_STAT: begin
          if (apb.pwrite) pslverr_c = 1'b1;
          else            prdata_c  = status;
        end
        ADDR_CTRL: begin
          if (!apb.pwrite) prdata_c = {30'b0, irq_en, enable};
        end
        default: pslverr_c = 1'b1;
      endcase
    end
  end

  assign apb.prdata  = prdata_c;
  assign apb.pslverr = pslverr_c;
  assign apb.pready  = 1'b1;

endmodule

// File: doc/tea_stream_feeder.md
Name: tea_stream_feeder

Overview:
APB-programmable streaming front end for the TEA cipher cores (tinyenc / tinydec).
- Software pushes 32-bit words into a TX FIFO.
- The block feeds each word to the cipher over the four-phase req/ack word handshake and captures the result into an RX FIFO.
- Software pops results over APB.
- It sits directly upstream of a cipher core: its wdata/req drive the core, and the core's rdata/ack return to it. It has its own APB psel, separate from the core's round register.

Parameters:
DEPTH, 4, entries per FIFO (power of two, 2..16)
AW, log2(DEPTH), FIFO pointer width; count width is AW+1
ACK_SYNC, 2, synchroniser flops on ack (0 = ack used directly)

Ports:
prstb  in  1  asynchronous active-low reset
pclk  in  1  APB/system clock; all state on posedge pclk
psel  in  1  APB select
penable  in  1  APB access phase
pwrite  in  1  APB write
paddr  in  4  byte address: 0x0 TXDATA(W), 0x4 RXDATA(R), 0x8 STATUS(R), 0xC CTRL(RW)
pwdata  in  32  APB write data
prdata  out  32  APB read data
pready  out  1  tied 1, no wait states
pslverr  out  1  error response
req  out  1  word request to the cipher core
wdata  out  32  word to the cipher core; stable while req=1
ack  in  1  cipher done/ack; treated as asynchronous
rdata  in  32  cipher result; valid when ack=1
irq  out  1  level interrupt

Behaviour:
Reset: already decided. Reset prstb, asynchronous, active-low; clock pclk.
- On reset: req=0, wdata=0, prdata=0, pslverr=0, irq=0, both FIFOs empty, CTRL=0, FSM=IDLE, ack synchroniser=0.
- Reset mid-handshake drops req immediately. The in-flight word is lost.

APB:
- An access is psel&penable.
- Write TXDATA pushes pwdata. If the TX FIFO is full, the push is dropped and pslverr=1.
- Read RXDATA returns the head and pops it. If the RX FIFO is empty, prdata=0, pslverr=1 and no pop occurs.
- STATUS layout:
  - [0] tx_empty
  - [1] tx_full
  - [2] rx_empty
  - [3] rx_full
  - [4] busy (FSM != IDLE)
  - [12:8] tx_count
  - [20:16] rx_count
  - other bits 0
- CTRL layout:
  - [0] enable
  - [1] irq_en
  - [2] flush: self-clearing, reads 0
- Any other address, or a write to RXDATA/STATUS, has no effect, returns prdata=0 and sets pslverr=1.
- prdata and pslverr are combinational, valid during the access phase.

FSM states: IDLE, REQ, REL.
- IDLE -> REQ when enable & ~tx_empty & ~rx_full.
  - On that edge: pop TX into wdata and set req=1.
- REQ -> REL when ack_s=1 (ack after synchronisation).
  - On that edge: push rdata into RX and set req=0.
  - If a discard flag is set, the result is not pushed.
- REL -> IDLE when ack_s=0.
- enable=0 only blocks new IDLE->REQ transitions. A handshake in progress completes.

Latency:
- APB push at edge E0 -> req=1 after E1.
- ack rise -> RX push ACK_SYNC+1 edges later.
- One word per handshake: minimum 2*(ACK_SYNC+1)+1 edges per word.

Boundaries:
- A simultaneous APB push and FSM pop on TX (or APB pop and FSM push on RX) in the same cycle both happen; the count is unchanged.
  - An APB push to TX when it holds DEPTH-1 entries while the FSM pops succeeds.
- The RX-full check is made at IDLE, so an RX push never overflows.
- Pointers wrap mod DEPTH.
- Flush empties both FIFOs in one cycle.
  - If the FSM is in REQ, the pending result is discarded but the handshake still completes.
  - A push that collides with flush is dropped (flush wins), without pslverr.

irq: registered. irq = irq_en & ~rx_empty.

Decomposition:
- Package tea_stream_pkg:
  - register address localparams (ADDR_TX, ADDR_RX, ADDR_STAT, ADDR_CTRL)
  - STATUS/CTRL bit-index constants
  - enum fsm_t {IDLE, REQ, REL}
- Sub-module tea_sfifo: synchronous FIFO with push, pop, flush, dout, count, full and empty; instantiated twice (TX and RX).

Test Plan:
1. Reset values: after reset, read STATUS -> 0x00000005, req=0, irq=0. Assert prstb=0 mid-REQ -> req=0 in the same cycle.
2. Loopback: model ack with 3-cycle latency and rdata=wdata^32'hA5A5A5A5.
   - Stimulus: CTRL=1, push 0x41424344.
   - Response: req rises 2 edges after the push; RXDATA read returns 0xE4E7E6E1; STATUS returns to 0x5.
3. Backpressure: ack model never completes. Push DEPTH+1 words.
   - After DEPTH+1 pushes, the first is in flight and TX holds DEPTH: tx_full=1. The next push gets pslverr=1 and tx_count stays 4.
   - Pop of empty RX -> pslverr=1, prdata=0.
4. RX full stall:
   - Stimulus: push 6 words with DEPTH=4 and no RX reads.
   - Response: exactly 4 handshakes; req stays 0 with rx_count=4, tx_count=2. After 1 RX pop, one more handshake occurs.
5. Flush mid-handshake: push 2 words, set flush while in REQ.
   - Response: req still completes the handshake; rx_count=0 and tx_count=0 afterwards.
6. Full chain with tinyenc→tinydec:
   - Stimulus: 33 random "A".."z" byte words.
   - Response: decrypted words equal the inputs in order. irq=1 whenever RX is non-empty with irq_en=1.
